// File: rtl/pwm_cap_pkg.sv
// rtl/pwm_cap_pkg.sv - shared state type, saturation constant and counter sizing for PWM capture
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        MEASURE = 2'd2
    } cap_state_t;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // Counters must reach 2*PERIOD-1 (the no-edge timeout) without wrapping.
    function automatic int cnt_width(input int period);
        return $clog2(2 * period) + 1;
    endfunction

endpackage

// File: rtl/pwm_cap_fifo.sv
// rtl/pwm_cap_fifo.sv - show-ahead synchronous FIFO with flush for captured samples
module pwm_cap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    // A pop frees the slot being written, so push-when-full is accepted alongside a pop.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_audio_capture.sv
// rtl/pwm_audio_capture.sv - PWM audio to 8-bit PCM capture; define PWM_CAP_AVG_EN for two-sample averaging
module pwm_audio_capture
    import pwm_cap_pkg::*;
#(
    parameter int PERIOD     = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pwm_in,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       locked,
    output logic       overflow
);

    localparam int             CW       = cnt_width(PERIOD);
    localparam logic [CW-1:0]  TIMEOUT  = CW'(2 * PERIOD - 1);
    localparam logic [CW-1:0]  SAT_WIDE = CW'(SAT_MAX);

    logic          r_s1, r_s2, r_s3;
    logic          w_rise;
    cap_state_t    r_state, w_state_next;
    logic [CW-1:0] r_frame_cnt, r_high_cnt;
    logic          w_push, w_flush, w_pop;
    logic [7:0]    w_raw, w_sample;
    logic          w_full, w_empty;
    logic          r_locked, r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = HUNT;
                HUNT:    if (w_rise) w_state_next = MEASURE;
                MEASURE: w_state_next = MEASURE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // A rising edge closes a frame; otherwise a stuck line reports full-scale or silence.
    always_comb begin
        w_push  = 1'b0;
        w_raw   = 8'h00;
        w_flush = 1'b0;
        if (!enable || r_state == IDLE) begin
            w_flush = 1'b1;
        end else if (r_state == MEASURE) begin
            if (w_rise) begin
                w_push = 1'b1;
                w_raw  = (r_high_cnt >= SAT_WIDE) ? SAT_MAX : r_high_cnt[7:0];
            end else if (r_frame_cnt == TIMEOUT) begin
                w_push = 1'b1;
                w_raw  = r_s2 ? SAT_MAX : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_high_cnt  <= '0;
        end else if (!enable || r_state == IDLE) begin
            r_frame_cnt <= '0;
            r_high_cnt  <= '0;
        end else if (w_rise) begin
            r_frame_cnt <= CW'(1);
            r_high_cnt  <= CW'(1);
        end else if (r_state == MEASURE) begin
            if (r_frame_cnt == TIMEOUT) begin
                r_frame_cnt <= '0;
                r_high_cnt  <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + CW'(1);
                r_high_cnt  <= r_high_cnt + {{(CW-1){1'b0}}, r_s2};
            end
        end
    end

`ifdef PWM_CAP_AVG_EN
    logic [7:0] r_prev;
    logic       r_have_prev;
    logic [8:0] w_sum;

    assign w_sum    = {1'b0, w_raw} + {1'b0, r_prev} + 9'd1;
    assign w_sample = r_have_prev ? w_sum[8:1] : w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev      <= 8'h00;
            r_have_prev <= 1'b0;
        end else if (!enable || r_state != MEASURE) begin
            r_have_prev <= 1'b0;
        end else if (w_push) begin
            r_prev      <= w_raw;
            r_have_prev <= 1'b1;
        end
    end
`else
    assign w_sample = w_raw;
`endif

    assign w_pop = ~w_empty & sample_ready;

    pwm_cap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_sample),
        .o_data  (sample_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_locked <= (w_state_next == MEASURE);
            if (w_flush) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign sample_valid = ~w_empty;
    assign locked       = r_locked;
    assign overflow     = r_overflow;

endmodule
